cgra_prr_array: RTL and testbench
=================================

// Module: cgra_prr_array
// PURPOSE
//  Behavioural CGRA array model for global-buffer system simulation: NUM_PRR independent partial-reconfig regions (PRRs).
//  - Each PRR has its own config port and a small register file.
//  - Each PRR streams GLB data in on column 0, applies a configurable op and latency, and returns it on column 1.
//  - Sits below global_buffer: g2f streams and cfg writes come in; f2g streams and cfg read data go out.
// PARAMETERS
//  NUM_PRR              16  number of regions (one per GLB tile)
//  CGRA_PER_GLB         2   io columns per region
//  CGRA_CFG_ADDR_WIDTH  32  config address width
//  CGRA_CFG_DATA_WIDTH  32  config data width
//  MAX_LAT              16  pipeline depth limit
// PORTS
//  clk          in   1                      single clock
//  reset        in   1                      asynchronous, active-low
//  stall        in   NUM_PRR                per-region pipeline freeze
//  cfg_wr_en    in   NUM_PRR                config write strobe
//  cfg_wr_addr  in   NUM_PRR x CFG_ADDR     write address
//  cfg_wr_data  in   NUM_PRR x CFG_DATA     write data
//  cfg_rd_en    in   NUM_PRR                config read strobe
//  cfg_rd_addr  in   NUM_PRR x CFG_ADDR     read address
//  cfg_rd_data  out  NUM_PRR x CFG_DATA     read data
//  io1_g2io     in   NUM_PRR x CGRA_PER_GLB       valid in; column 0 used
//  io16_g2io    in   NUM_PRR x CGRA_PER_GLB x 16  data in; column 0 used
//  io1_io2g     out  NUM_PRR x CGRA_PER_GLB       valid out; column 1 driven
//  io16_io2g    out  NUM_PRR x CGRA_PER_GLB x 16  data out; column 1 driven
// BEHAVIOUR
//  Reset values
//  - All registers, pipelines, cfg_rd_data and all outputs are 0.
//  - Column 0 of the io2g outputs is tied 0; column 1 of the g2io inputs is ignored.
//  Register map per region (addr[7:0] selects; upper bits ignored; unmapped addresses read 0, writes dropped)
//  - 0x00 CTRL:  bit0 EN, bits[2:1] OP (0 pass, 1 add CONST, 2 mul CONST low 16b, 3 xor CONST).
//  - 0x01 LAT:   bits[3:0]; total latency = LAT+1 cycles.
//  - 0x02 CONST: bits[15:0].
//  - 0x03 COUNT: output-valid beat counter, 32-bit, saturating; any write clears it to 0.
//  Config port
//  - Writes take effect on the next edge.
//  - Read data is registered: valid one cycle after cfg_rd_en and held until the next read.
//  - Simultaneous rd and wr to the same address returns the old value.
//  Datapath
//  - Input sample: {io1_g2io[p][0], io16_g2io[p][0]}.
//  - Op result is wrapped to 16 bits. It enters a MAX_LAT-deep shift register; the output tap is LAT.
//  - io1_io2g[p][1] = tap valid & EN; io16_io2g[p][1] = tap data when valid, else 0.
//  - stall[p]=1: shift register and COUNT hold; io1_io2g[p][1] is forced 0; config access stays live.
//  - EN=0 clears the pipeline valid bits.
//  - Changing LAT mid-stream re-taps immediately; in-flight words may be duplicated or dropped. This is legal.
//  - reset asserted mid-stream: outputs go 0 immediately.
// STRUCTURE
//  - Shared package: width constants from global_buffer_param plus an op enum and register-address localparams.
//  - Sub-module cgra_prr: one region (regs + pipeline); top generates NUM_PRR copies.
// TESTING
//  - Reset: after reset release, read all 4 regs of each PRR -> 0; io1_io2g all 0.
//  - Passthrough: EN=1, OP=0, LAT=3; drive 8 valid words 0x0001..0x0008 on col0 -> same words on col1 4 cycles later; COUNT reads 8.
//  - Add with wrap: OP=1, CONST=0x0002, input 0xFFFF -> output 0x0001; mul OP=2, CONST=3, input 0x0005 -> 0x000F.
//  - Stall: assert stall for 5 cycles mid-stream -> no valid out during stall; order and count preserved after release.
//  - Isolation: configure PRR 3 only -> other PRRs output no valids and read CTRL=0.
//  - Config corner: write COUNT -> reads 0; read unmapped 0x10 -> 0; same-cycle rd/wr CONST returns old value.

Source files
------------

// File: rtl/cgra_prr_array_pkg.sv
// Shared constants, op encoding and register map for the CGRA PRR array model.
package cgra_prr_array_pkg;

    localparam int unsigned NUM_PRR             = 16;
    localparam int unsigned CGRA_PER_GLB        = 2;
    localparam int unsigned CGRA_CFG_ADDR_WIDTH = 32;
    localparam int unsigned CGRA_CFG_DATA_WIDTH = 32;
    localparam int unsigned MAX_LAT             = 16;
    localparam int unsigned IO_WIDTH            = 16;
    localparam int unsigned LAT_WIDTH           = 4;
    localparam int unsigned REG_ADDR_WIDTH      = 8;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_ADD  = 2'd1,
        OP_MUL  = 2'd2,
        OP_XOR  = 2'd3
    } op_e;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_CTRL  = 8'h00;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_LAT   = 8'h01;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_CONST = 8'h02;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_COUNT = 8'h03;

    // Region op, result wrapped to the io width.
    function automatic logic [IO_WIDTH-1:0] apply_op(input op_e op,
                                                     input logic [IO_WIDTH-1:0] d,
                                                     input logic [IO_WIDTH-1:0] c);
        logic [IO_WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = IO_WIDTH'(d + c);
            OP_MUL:  r = IO_WIDTH'(d * c);
            OP_XOR:  r = d ^ c;
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cgra_prr_array_prr.sv
// One partial-reconfig region: config registers, op stage and tapped delay line.
module cgra_prr
    import cgra_prr_array_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           cfg_wr_en,
    input  logic [CGRA_CFG_ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic [CGRA_CFG_DATA_WIDTH-1:0] cfg_wr_data,
    input  logic                           cfg_rd_en,
    input  logic [CGRA_CFG_ADDR_WIDTH-1:0] cfg_rd_addr,
    output logic [CGRA_CFG_DATA_WIDTH-1:0] cfg_rd_data,
    input  logic                           in_valid,
    input  logic [IO_WIDTH-1:0]            in_data,
    output logic                           out_valid,
    output logic [IO_WIDTH-1:0]            out_data
);

    logic                               en;
    op_e                                op;
    logic [LAT_WIDTH-1:0]               lat;
    logic [IO_WIDTH-1:0]                cnst;
    logic [CGRA_CFG_DATA_WIDTH-1:0]     count;
    logic [MAX_LAT-1:0]                 valid_sr;
    logic [MAX_LAT-1:0][IO_WIDTH-1:0]   data_sr;
    logic [CGRA_CFG_DATA_WIDTH-1:0]     rd_mux;
    logic [REG_ADDR_WIDTH-1:0]          wr_sel;
    logic [REG_ADDR_WIDTH-1:0]          rd_sel;
    logic                               unused_bits;

    assign wr_sel = cfg_wr_addr[REG_ADDR_WIDTH-1:0];
    assign rd_sel = cfg_rd_addr[REG_ADDR_WIDTH-1:0];
    assign unused_bits = ^{cfg_wr_addr[CGRA_CFG_ADDR_WIDTH-1:REG_ADDR_WIDTH],
                           cfg_rd_addr[CGRA_CFG_ADDR_WIDTH-1:REG_ADDR_WIDTH],
                           cfg_wr_data[CGRA_CFG_DATA_WIDTH-1:IO_WIDTH]};

    // Output tap follows LAT immediately; stall masks the beat without losing it.
    assign out_valid = valid_sr[lat] & en & ~stall;
    assign out_data  = out_valid ? data_sr[lat] : '0;

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            REG_CTRL:  rd_mux = CGRA_CFG_DATA_WIDTH'({op, en});
            REG_LAT:   rd_mux = CGRA_CFG_DATA_WIDTH'(lat);
            REG_CONST: rd_mux = CGRA_CFG_DATA_WIDTH'(cnst);
            REG_COUNT: rd_mux = count;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en          <= 1'b0;
            op          <= OP_PASS;
            lat         <= '0;
            cnst        <= '0;
            count       <= '0;
            valid_sr    <= '0;
            data_sr     <= '0;
            cfg_rd_data <= '0;
        end else begin
            if (cfg_wr_en) begin
                case (wr_sel)
                    REG_CTRL: begin
                        en <= cfg_wr_data[0];
                        op <= op_e'(cfg_wr_data[2:1]);
                    end
                    REG_LAT:   lat  <= cfg_wr_data[LAT_WIDTH-1:0];
                    REG_CONST: cnst <= cfg_wr_data[IO_WIDTH-1:0];
                    default: ;
                endcase
            end

            if (cfg_wr_en && (wr_sel == REG_COUNT)) begin
                count <= '0;
            end else if (out_valid && (count != '1)) begin
                count <= count + CGRA_CFG_DATA_WIDTH'(1);
            end

            if (cfg_rd_en) begin
                cfg_rd_data <= rd_mux;
            end

            // Disabling the region flushes in-flight beats.
            if (!en) begin
                valid_sr <= '0;
            end else if (!stall) begin
                valid_sr <= {valid_sr[MAX_LAT-2:0], in_valid};
                data_sr  <= {data_sr[MAX_LAT-2:0], apply_op(op, in_data, cnst)};
            end
        end
    end

endmodule

// File: rtl/cgra_prr_array.sv
// Array of independent PRRs below the global buffer: column 0 in, column 1 out.
module cgra_prr_array
    import cgra_prr_array_pkg::*;
(
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_PRR-1:0]                            stall,
    input  logic [NUM_PRR-1:0]                            cfg_wr_en,
    input  logic [NUM_PRR-1:0][CGRA_CFG_ADDR_WIDTH-1:0]   cfg_wr_addr,
    input  logic [NUM_PRR-1:0][CGRA_CFG_DATA_WIDTH-1:0]   cfg_wr_data,
    input  logic [NUM_PRR-1:0]                            cfg_rd_en,
    input  logic [NUM_PRR-1:0][CGRA_CFG_ADDR_WIDTH-1:0]   cfg_rd_addr,
    output logic [NUM_PRR-1:0][CGRA_CFG_DATA_WIDTH-1:0]   cfg_rd_data,
    input  logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]          io1_g2io,
    input  logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0][IO_WIDTH-1:0] io16_g2io,
    output logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]          io1_io2g,
    output logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0][IO_WIDTH-1:0] io16_io2g
);

    for (genvar p = 0; p < int'(NUM_PRR); p++) begin : g_prr
        logic unused_col1;
        assign unused_col1 = ^{io1_g2io[p][1], io16_g2io[p][1]};

        assign io1_io2g[p][0]  = 1'b0;
        assign io16_io2g[p][0] = '0;

        cgra_prr u_prr (
            .clk         (clk),
            .reset       (reset),
            .stall       (stall[p]),
            .cfg_wr_en   (cfg_wr_en[p]),
            .cfg_wr_addr (cfg_wr_addr[p]),
            .cfg_wr_data (cfg_wr_data[p]),
            .cfg_rd_en   (cfg_rd_en[p]),
            .cfg_rd_addr (cfg_rd_addr[p]),
            .cfg_rd_data (cfg_rd_data[p]),
            .in_valid    (io1_g2io[p][0]),
            .in_data     (io16_g2io[p][0]),
            .out_valid   (io1_io2g[p][1]),
            .out_data    (io16_io2g[p][1])
        );
    end

endmodule

// File: tb/tb_cgra_prr_array.sv
// Randomized self-checking bench for cgra_prr_array with a behavioural region model.
module tb_cgra_prr_array;
    import cgra_prr_array_pkg::*;

    logic                                        clk;
    logic                                        reset;
    logic [NUM_PRR-1:0]                          stall;
    logic [NUM_PRR-1:0]                          cfg_wr_en;
    logic [NUM_PRR-1:0][CGRA_CFG_ADDR_WIDTH-1:0] cfg_wr_addr;
    logic [NUM_PRR-1:0][CGRA_CFG_DATA_WIDTH-1:0] cfg_wr_data;
    logic [NUM_PRR-1:0]                          cfg_rd_en;
    logic [NUM_PRR-1:0][CGRA_CFG_ADDR_WIDTH-1:0] cfg_rd_addr;
    logic [NUM_PRR-1:0][CGRA_CFG_DATA_WIDTH-1:0] cfg_rd_data;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]        io1_g2io;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0][15:0]  io16_g2io;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0]        io1_io2g;
    logic [NUM_PRR-1:0][CGRA_PER_GLB-1:0][15:0]  io16_io2g;

    cgra_prr_array dut (
        .clk(clk), .reset(reset), .stall(stall),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
        .io1_g2io(io1_g2io), .io16_g2io(io16_g2io),
        .io1_io2g(io1_io2g), .io16_io2g(io16_io2g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: architectural registers plus a history of accepted samples (index 0 = newest).
    logic        m_en   [NUM_PRR];
    logic [1:0]  m_op   [NUM_PRR];
    logic [3:0]  m_lat  [NUM_PRR];
    logic [15:0] m_const[NUM_PRR];
    logic [31:0] m_count[NUM_PRR];
    logic [31:0] m_rd   [NUM_PRR];
    bit          hv[NUM_PRR][$];
    logic [15:0] hd[NUM_PRR][$];

    int          cap_p = 0;
    logic [15:0] cap_q[$];
    int          cap_cyc[$];
    int          vcount[NUM_PRR];
    int          stall_viol = 0;
    logic        cmp_ev;
    logic [15:0] cmp_ed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_op(input logic [1:0] op, input logic [15:0] d,
                                             input logic [15:0] c);
        longint unsigned a, b;
        a = longint'(d);
        b = longint'(c);
        case (op)
            2'd1:    return 16'((a + b) % 65536);
            2'd2:    return 16'((a * b) % 65536);
            2'd3:    return d ^ c;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int p, input logic [7:0] a);
        case (a)
            8'h00:   return {29'd0, m_op[p], m_en[p]};
            8'h01:   return {28'd0, m_lat[p]};
            8'h02:   return {16'd0, m_const[p]};
            8'h03:   return m_count[p];
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < NUM_PRR; p++) begin
            m_en[p] = 1'b0; m_op[p] = '0; m_lat[p] = '0; m_const[p] = '0;
            m_count[p] = '0; m_rd[p] = '0;
            hv[p].delete(); hd[p].delete();
            for (int k = 0; k < MAX_LAT; k++) begin
                hv[p].push_back(1'b0);
                hd[p].push_back(16'h0);
            end
        end
    endfunction

    function automatic void model_step();
        for (int p = 0; p < NUM_PRR; p++) begin
            bit ov;
            logic [7:0] wa;
            ov = m_en[p] && !stall[p] && hv[p][m_lat[p]];
            wa = cfg_wr_addr[p][7:0];
            if (cfg_rd_en[p]) m_rd[p] = model_read(p, cfg_rd_addr[p][7:0]);
            if (!m_en[p]) begin
                for (int k = 0; k < MAX_LAT; k++) hv[p][k] = 1'b0;
            end else if (!stall[p]) begin
                hv[p].push_front(io1_g2io[p][0]);
                hd[p].push_front(model_op(m_op[p], io16_g2io[p][0], m_const[p]));
                void'(hv[p].pop_back());
                void'(hd[p].pop_back());
            end
            if (cfg_wr_en[p] && wa == 8'h03) m_count[p] = 0;
            else if (ov && m_count[p] != 32'hFFFF_FFFF) m_count[p] = m_count[p] + 1;
            if (cfg_wr_en[p]) begin
                case (wa)
                    8'h00: begin m_en[p] = cfg_wr_data[p][0]; m_op[p] = cfg_wr_data[p][2:1]; end
                    8'h01: m_lat[p]   = cfg_wr_data[p][3:0];
                    8'h02: m_const[p] = cfg_wr_data[p][15:0];
                    default: ;
                endcase
            end
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset) model_reset();
        else model_step();
    end

    // Every cycle: all outputs of every region against the model.
    always @(negedge clk) begin
        for (int p = 0; p < NUM_PRR; p++) begin
            cmp_ev = reset && m_en[p] && !stall[p] && hv[p][m_lat[p]];
            cmp_ed = cmp_ev ? hd[p][m_lat[p]] : 16'h0;
            check($sformatf("io1_io2g[%0d]", p), 32'(io1_io2g[p]), {30'd0, cmp_ev, 1'b0});
            check($sformatf("io16_io2g[%0d]", p), 32'(io16_io2g[p]), {cmp_ed, 16'h0});
            check($sformatf("cfg_rd_data[%0d]", p), cfg_rd_data[p], m_rd[p]);
            if (io1_io2g[p][1] === 1'b1) begin
                vcount[p]++;
                if (stall[p]) stall_viol++;
                if (p == cap_p) begin
                    cap_q.push_back(io16_io2g[p][1]);
                    cap_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = '0; cfg_wr_en = '0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_rd_en = '0; cfg_rd_addr = '0; io1_g2io = '0; io16_g2io = '0;
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d);
        cfg_wr_en[p] = 1'b1; cfg_wr_addr[p] = a; cfg_wr_data[p] = d;
        tick();
        cfg_wr_en[p] = 1'b0;
    endtask

    task automatic rd_check(input int p, input logic [31:0] a, input logic [31:0] exp,
                            input string name);
        cfg_rd_en[p] = 1'b1; cfg_rd_addr[p] = a;
        tick();
        cfg_rd_en[p] = 1'b0;
        check(name, cfg_rd_data[p], exp);
    endtask

    task automatic clear_capture(input int p);
        cap_p = p;
        cap_q.delete();
        cap_cyc.delete();
    endtask

    initial begin
        int t0;
        int idx;
        logic [31:0] a;
        model_reset();
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset state: every register of every region reads 0.
        for (int r = 0; r < 4; r++) begin
            cfg_rd_en = '1;
            for (int p = 0; p < NUM_PRR; p++) cfg_rd_addr[p] = 32'(r);
            tick();
            cfg_rd_en = '0;
            for (int p = 0; p < NUM_PRR; p++)
                check($sformatf("reset_reg%0d_prr%0d", r, p), cfg_rd_data[p], 32'd0);
        end
        check("reset_io1", 32'(io1_io2g), 32'd0);

        // Passthrough, LAT=3: words 1..8 return 4 cycles later, COUNT=8.
        wr(0, 32'h0, 32'h1);
        wr(0, 32'h1, 32'h3);
        clear_capture(0);
        t0 = cyc;
        for (int i = 1; i <= 8; i++) begin
            io1_g2io[0][0] = 1'b1; io16_g2io[0][0] = 16'(i);
            tick();
        end
        io1_g2io[0][0] = 1'b0;
        repeat (6) tick();
        check("pass_count_beats", 32'(cap_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            check($sformatf("pass_word%0d", i), 32'(cap_q[i]), 32'(i + 1));
        if (cap_cyc.size() > 0) check("pass_latency", 32'(cap_cyc[0] - t0), 32'd4);
        rd_check(0, 32'h3, 32'd8, "pass_COUNT");

        // Add with wrap on PRR1, multiply on PRR2.
        wr(1, 32'h2, 32'h0002);
        wr(1, 32'h0, 32'h3);
        clear_capture(1);
        io1_g2io[1][0] = 1'b1; io16_g2io[1][0] = 16'hFFFF;
        tick();
        io1_g2io[1][0] = 1'b0;
        repeat (3) tick();
        check("add_wrap", cap_q.size() > 0 ? 32'(cap_q[0]) : 32'hDEAD, 32'h0001);
        wr(2, 32'h2, 32'h0003);
        wr(2, 32'h0, 32'h5);
        clear_capture(2);
        io1_g2io[2][0] = 1'b1; io16_g2io[2][0] = 16'h0005;
        tick();
        io1_g2io[2][0] = 1'b0;
        repeat (3) tick();
        check("mul", cap_q.size() > 0 ? 32'(cap_q[0]) : 32'hDEAD, 32'h000F);

        // Stall 5 cycles mid-stream: order and count preserved.
        wr(0, 32'h3, 32'h0);
        rd_check(0, 32'h3, 32'd0, "count_cleared");
        clear_capture(0);
        stall_viol = 0;
        idx = 1;
        for (int c = 0; c < 15; c++) begin
            stall[0] = (c >= 4 && c < 9);
            io1_g2io[0][0] = 1'b1; io16_g2io[0][0] = 16'(32'h100 + idx);
            tick();
            if (!stall[0]) idx++;
        end
        stall[0] = 1'b0; io1_g2io[0][0] = 1'b0;
        repeat (6) tick();
        check("stall_beats", 32'(cap_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < cap_q.size(); i++)
            check($sformatf("stall_word%0d", i), 32'(cap_q[i]), 32'h101 + 32'(i));
        check("stall_no_valid", 32'(stall_viol), 32'd0);
        rd_check(0, 32'h3, 32'd10, "stall_COUNT");

        // Reset mid-stream: outputs drop to 0 at once.
        io1_g2io[0][0] = 1'b1;
        repeat (5) tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("midreset_io1", 32'(io1_io2g), 32'd0);
        check("midreset_io16", 32'(io16_io2g[0]), 32'd0);
        clear_inputs();
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Isolation: only PRR3 configured.
        wr(3, 32'h1, 32'h2);
        wr(3, 32'h0, 32'h1);
        for (int p = 0; p < NUM_PRR; p++) vcount[p] = 0;
        for (int c = 0; c < 20; c++) begin
            for (int p = 0; p < NUM_PRR; p++) begin
                io1_g2io[p] = 2'b11;
                io16_g2io[p] = 32'($urandom);
            end
            tick();
        end
        io1_g2io = '0;
        repeat (5) tick();
        t0 = 0;
        for (int p = 0; p < NUM_PRR; p++) if (p != 3) t0 += vcount[p];
        check("iso_others_valid", 32'(t0), 32'd0);
        check("iso_prr3_valid", 32'(vcount[3]), 32'd20);
        cfg_rd_en = '1; cfg_rd_addr = '0;
        tick();
        cfg_rd_en = '0;
        for (int p = 0; p < NUM_PRR; p++)
            check($sformatf("iso_ctrl%0d", p), cfg_rd_data[p], (p == 3) ? 32'd1 : 32'd0);

        // Config corners on PRR5.
        wr(5, 32'h10, 32'hFFFF_FFFF);
        rd_check(5, 32'h10, 32'd0, "unmapped_read");
        wr(5, 32'h0000_0102, 32'h1234);
        rd_check(5, 32'hFF00_0002, 32'h1234, "upper_addr_ignored");
        cfg_wr_en[5] = 1'b1; cfg_wr_addr[5] = 32'h2; cfg_wr_data[5] = 32'hABCD;
        cfg_rd_en[5] = 1'b1; cfg_rd_addr[5] = 32'h2;
        tick();
        cfg_wr_en[5] = 1'b0; cfg_rd_en[5] = 1'b0;
        check("rdwr_old_value", cfg_rd_data[5], 32'h1234);
        tick();
        check("rd_data_held", cfg_rd_data[5], 32'h1234);
        rd_check(5, 32'h2, 32'hABCD, "rdwr_new_value");

        // Randomized traffic, config churn and stalls on all regions.
        for (int p = 0; p < NUM_PRR; p++) begin
            cfg_wr_en[p] = 1'b1; cfg_wr_addr[p] = 32'h0;
            cfg_wr_data[p] = {29'd0, 2'($urandom), 1'b1};
        end
        tick();
        cfg_wr_en = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < NUM_PRR; p++) begin
                stall[p] = ($urandom_range(7) == 0);
                io1_g2io[p] = 2'($urandom);
                io16_g2io[p] = 32'($urandom);
                cfg_wr_en[p] = ($urandom_range(15) == 0);
                case ($urandom_range(4))
                    0: a = 32'h00; 1: a = 32'h01; 2: a = 32'h02; 3: a = 32'h03;
                    default: a = 32'h10;
                endcase
                cfg_wr_addr[p] = {24'($urandom), a[7:0]};
                cfg_wr_data[p] = $urandom;
                if (a == 32'h0) cfg_wr_data[p][0] = ($urandom_range(3) != 0);
                cfg_rd_en[p] = ($urandom_range(3) == 0);
                cfg_rd_addr[p] = {24'($urandom), 8'($urandom_range(4) == 4 ? 8'h10
                                                  : 8'($urandom_range(3)))};
            end
            tick();
        end
        clear_inputs();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
